// File: rtl/i2c_slave_responder.sv
// I2C target answering SLAVE_ADDR: ACKs its address, delivers written bytes, and shifts read bytes onto SDA.
// Define I2C_GLITCH_FILTER_EN to add a 3-sample majority filter on SCL/SDA after the synchronizer.
module i2c_slave_responder #(
  parameter logic [6:0] SLAVE_ADDR = 7'd48
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [7:0] rd_data_in,
  output logic       rd_strobe,
  output logic [7:0] wr_data_out,
  output logic       wr_strobe,
  output logic       busy
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ADDR      = 3'd1;
  localparam logic [2:0] S_ADDR_ACK  = 3'd2;
  localparam logic [2:0] S_WR_BYTE   = 3'd3;
  localparam logic [2:0] S_WR_ACK    = 3'd4;
  localparam logic [2:0] S_RD_BYTE   = 3'd5;
  localparam logic [2:0] S_RD_ACK    = 3'd6;
  localparam logic [2:0] S_WAIT_STOP = 3'd7;

  logic [1:0] scl_sync, sda_sync;
  logic       scl, sda, scl_prev, sda_prev;

  // Synchronizers reset to the idle-bus level so reset release never looks like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  logic [1:0] scl_hist, sda_hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_hist <= '1;
      sda_hist <= '1;
    end else begin
      scl_hist <= {scl_hist[0], scl_sync[1]};
      sda_hist <= {sda_hist[0], sda_sync[1]};
    end
  end

  assign scl = (scl_sync[1] & scl_hist[0]) | (scl_sync[1] & scl_hist[1]) | (scl_hist[0] & scl_hist[1]);
  assign sda = (sda_sync[1] & sda_hist[0]) | (sda_sync[1] & sda_hist[1]) | (sda_hist[0] & sda_hist[1]);
`else
  assign scl = scl_sync[1];
  assign sda = sda_sync[1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_prev <= scl;
      sda_prev <= sda;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl & ~scl_prev;
  assign scl_fall  = ~scl & scl_prev;
  assign start_det = scl & scl_prev & sda_prev & ~sda;
  assign stop_det  = scl & scl_prev & ~sda_prev & sda;

  logic [2:0] state;
  logic [3:0] bit_cnt;
  logic [7:0] shifter, tx;
  logic [7:0] shift_in;
  logic       rw, ack_hold;

  assign shift_in = {shifter[6:0], sda};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      bit_cnt     <= '0;
      shifter     <= '0;
      tx          <= '0;
      rw          <= 1'b0;
      ack_hold    <= 1'b0;
      sda_oe      <= 1'b0;
      busy        <= 1'b0;
      wr_data_out <= '0;
      wr_strobe   <= 1'b0;
      rd_strobe   <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      rd_strobe <= 1'b0;
      if (start_det) begin
        state    <= S_ADDR;
        bit_cnt  <= '0;
        ack_hold <= 1'b0;
        sda_oe   <= 1'b0;
        busy     <= 1'b0;
      end else if (stop_det) begin
        state    <= S_IDLE;
        bit_cnt  <= '0;
        ack_hold <= 1'b0;
        sda_oe   <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          S_IDLE: ;
          S_ADDR: if (scl_rise) begin
            shifter <= shift_in;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt <= '0;
              if (shift_in[7:1] == SLAVE_ADDR) begin
                rw    <= shift_in[0];
                busy  <= 1'b1;
                state <= S_ADDR_ACK;
              end else begin
                state <= S_WAIT_STOP;
              end
            end
          end
          // ACK spans two SCL falls: the first pulls SDA, the second ends the 9th clock.
          S_ADDR_ACK, S_WR_ACK: if (scl_fall) begin
            if (!ack_hold) begin
              sda_oe   <= 1'b1;
              ack_hold <= 1'b1;
            end else begin
              ack_hold <= 1'b0;
              bit_cnt  <= '0;
              if (state == S_ADDR_ACK && rw) begin
                tx        <= {rd_data_in[6:0], 1'b0};
                sda_oe    <= ~rd_data_in[7];
                rd_strobe <= 1'b1;
                bit_cnt   <= 4'd1;
                state     <= S_RD_BYTE;
              end else begin
                sda_oe <= 1'b0;
                state  <= S_WR_BYTE;
              end
            end
          end
          S_WR_BYTE: if (scl_rise) begin
            shifter <= shift_in;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              wr_data_out <= shift_in;
              wr_strobe   <= 1'b1;
              bit_cnt     <= '0;
              state       <= S_WR_ACK;
            end
          end
          S_RD_BYTE: if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
              state   <= S_RD_ACK;
            end else begin
              sda_oe  <= ~tx[7];
              tx      <= {tx[6:0], 1'b0};
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          // After a master ACK the byte is loaded now; its MSB goes out on the next SCL fall.
          S_RD_ACK: if (scl_rise) begin
            if (!sda) begin
              tx        <= rd_data_in;
              rd_strobe <= 1'b1;
              bit_cnt   <= '0;
              state     <= S_RD_BYTE;
            end else begin
              state <= S_WAIT_STOP;
            end
          end
          S_WAIT_STOP: sda_oe <= 1'b0;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench for i2c_slave_responder: a bus-master model drives SCL/SDA and checks ACKs, data and strobes.
module tb_i2c_slave_responder;

  localparam int unsigned Q = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe;
  logic [7:0] rd_data_in = 8'h00;
  logic       rd_strobe;
  logic [7:0] wr_data_out;
  logic       wr_strobe;
  logic       busy;

  int errors = 0;
  int checks = 0;

  int unsigned wr_pulses = 0, rd_pulses = 0, oe_cycles = 0, busy_cycles = 0;
  bit both_seen = 1'b0;

  assign sda_line = sda_m & ~sda_oe;

  i2c_slave_responder #(.SLAVE_ADDR(7'd48)) dut (
    .clk(clk), .rst(rst), .scl_in(scl_m), .sda_in(sda_line), .sda_oe(sda_oe),
    .rd_data_in(rd_data_in), .rd_strobe(rd_strobe), .wr_data_out(wr_data_out),
    .wr_strobe(wr_strobe), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_strobe) wr_pulses++;
    if (rd_strobe) rd_pulses++;
    if (sda_oe) oe_cycles++;
    if (busy) busy_cycles++;
    if (wr_strobe && rd_strobe) both_seen = 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "timeout");
  end

  task automatic wait_clk(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    scl_m = 1'b1; sda_m = 1'b1; wait_clk(2*Q);
    sda_m = 1'b0; wait_clk(2*Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic bus_rstart();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(2*Q);
    sda_m = 1'b1; wait_clk(2*Q);
  endtask

  task automatic bus_write(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; wait_clk(Q);
      scl_m = 1'b1; wait_clk(2*Q);
      scl_m = 1'b0; wait_clk(Q);
    end
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    ack = sda_line; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic bus_read(input logic master_ack, output logic [7:0] b);
    b = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; wait_clk(Q);
      scl_m = 1'b1; wait_clk(Q);
      b[i] = sda_line; wait_clk(Q);
      scl_m = 1'b0; wait_clk(Q);
    end
    sda_m = master_ack; wait_clk(Q);
    scl_m = 1'b1; wait_clk(2*Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic test_reset();
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    wait_clk(3);
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
    checks++; if (wr_data_out !== 8'h00) begin errors++; $display("FAIL reset_wr_data: got %h want 00", wr_data_out); end
    checks++; if ({wr_strobe, rd_strobe, busy} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {wr_strobe, rd_strobe, busy}); end
    rst = 1'b0;
    wait_clk(4);
  endtask

  task automatic test_write();
    logic a0, a1;
    int unsigned w0, r0;
    w0 = wr_pulses; r0 = rd_pulses;
    bus_start();
    bus_write(8'h60, a0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy: got %b want 1", busy); end
    bus_write(8'h0C, a1);
    bus_stop();
    checks++; if (a0 !== 1'b0) begin errors++; $display("FAIL write_addr_ack: got %b want 0", a0); end
    checks++; if (a1 !== 1'b0) begin errors++; $display("FAIL write_data_ack: got %b want 0", a1); end
    checks++; if (wr_data_out !== 8'h0C) begin errors++; $display("FAIL write_data: got %h want 0c", wr_data_out); end
    checks++; if (wr_pulses - w0 != 1) begin errors++; $display("FAIL write_strobes: got %0d want 1", wr_pulses - w0); end
    checks++; if (rd_pulses - r0 != 0) begin errors++; $display("FAIL write_rd_strobes: got %0d want 0", rd_pulses - r0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_after_stop: got %b want 0", busy); end
  endtask

  task automatic test_read();
    logic a0;
    logic [7:0] b;
    int unsigned w0, r0;
    w0 = wr_pulses; r0 = rd_pulses;
    rd_data_in = 8'hA5;
    bus_start();
    bus_write(8'h61, a0);
    bus_read(1'b1, b);
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL read_release_after_nack: got %b want 0", sda_oe); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL read_busy_wait_stop: got %b want 1", busy); end
    bus_stop();
    checks++; if (a0 !== 1'b0) begin errors++; $display("FAIL read_addr_ack: got %b want 0", a0); end
    checks++; if (b !== 8'hA5) begin errors++; $display("FAIL read_data: got %h want a5", b); end
    checks++; if (rd_pulses - r0 != 1) begin errors++; $display("FAIL read_strobes: got %0d want 1", rd_pulses - r0); end
    checks++; if (wr_pulses - w0 != 0) begin errors++; $display("FAIL read_wr_strobes: got %0d want 0", wr_pulses - w0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_busy_after_stop: got %b want 0", busy); end
  endtask

  task automatic test_mismatch();
    logic a0, a1;
    int unsigned w0, r0, o0, b0;
    w0 = wr_pulses; r0 = rd_pulses; o0 = oe_cycles; b0 = busy_cycles;
    bus_start();
    bus_write(8'h62, a0);
    bus_write(8'h0C, a1);
    bus_stop();
    checks++; if ({a0, a1} !== 2'b11) begin errors++; $display("FAIL mismatch_acks: got %b want 11", {a0, a1}); end
    checks++; if (oe_cycles - o0 != 0) begin errors++; $display("FAIL mismatch_sda_oe: got %0d cycles want 0", oe_cycles - o0); end
    checks++; if (wr_pulses - w0 + rd_pulses - r0 != 0) begin errors++; $display("FAIL mismatch_strobes: got %0d want 0", wr_pulses - w0 + rd_pulses - r0); end
    checks++; if (busy_cycles - b0 != 0) begin errors++; $display("FAIL mismatch_busy: got %0d cycles want 0", busy_cycles - b0); end
  endtask

  task automatic test_repeated_start();
    logic a0, a1, a2;
    logic [7:0] b0, b1;
    int unsigned w0, r0;
    w0 = wr_pulses; r0 = rd_pulses;
    rd_data_in = 8'h3C;
    bus_start();
    bus_write(8'h60, a0);
    bus_write(8'h11, a1);
    bus_rstart();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstart_busy_cleared: got %b want 0", busy); end
    bus_write(8'h61, a2);
    bus_read(1'b0, b0);
    bus_read(1'b1, b1);
    bus_stop();
    checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL rstart_acks: got %b want 000", {a0, a1, a2}); end
    checks++; if (wr_data_out !== 8'h11) begin errors++; $display("FAIL rstart_wr_data: got %h want 11", wr_data_out); end
    checks++; if (b0 !== 8'h3C || b1 !== 8'h3C) begin errors++; $display("FAIL rstart_read_data: got %h %h want 3c 3c", b0, b1); end
    checks++; if (rd_pulses - r0 != 2) begin errors++; $display("FAIL rstart_rd_strobes: got %0d want 2", rd_pulses - r0); end
    checks++; if (wr_pulses - w0 != 1) begin errors++; $display("FAIL rstart_wr_strobes: got %0d want 1", wr_pulses - w0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    logic [2:0] acks;
    logic a;
    int unsigned w0;
    bytes[0] = 8'hFF; bytes[1] = 8'h00; bytes[2] = 8'h5A;
    w0 = wr_pulses;
    bus_start();
    bus_write(8'h60, a);
    for (int i = 0; i < 3; i++) begin
      bus_write(bytes[i], acks[i]);
      checks++; if (wr_data_out !== bytes[i]) begin errors++; $display("FAIL b2b_byte%0d: got %h want %h", i, wr_data_out, bytes[i]); end
    end
    // A partial byte before STOP must not strobe.
    for (int i = 0; i < 3; i++) begin
      sda_m = 1'b1; wait_clk(Q);
      scl_m = 1'b1; wait_clk(2*Q);
      scl_m = 1'b0; wait_clk(Q);
    end
    bus_stop();
    checks++; if ({a, acks} !== 4'b0000) begin errors++; $display("FAIL b2b_acks: got %b want 0000", {a, acks}); end
    checks++; if (wr_pulses - w0 != 3) begin errors++; $display("FAIL b2b_strobes: got %0d want 3", wr_pulses - w0); end
    checks++; if (wr_data_out !== 8'h5A) begin errors++; $display("FAIL b2b_partial_kept: got %h want 5a", wr_data_out); end
    checks++; if (both_seen !== 1'b0) begin errors++; $display("FAIL strobe_overlap: got %b want 0", both_seen); end
  endtask

  task automatic test_reset_mid_read();
    logic a0, a1;
    int unsigned n;
    rd_data_in = 8'h00;
    bus_start();
    bus_write(8'h61, a0);
    n = 0;
    while (sda_oe !== 1'b1 && n < 20) begin wait_clk(1); n++; end
    checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL rst_mid_drive: got %b want 1", sda_oe); end
    rst = 1'b1;
    #1;
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rst_mid_release: got %b want 0", sda_oe); end
    wait_clk(3);
    rst = 1'b0;
    sda_m = 1'b1; scl_m = 1'b1;
    wait_clk(4*Q);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    bus_start();
    bus_write(8'h60, a1);
    bus_stop();
    checks++; if (a1 !== 1'b0) begin errors++; $display("FAIL rst_mid_next_ack: got %b want 0", a1); end
  endtask

`ifdef I2C_GLITCH_FILTER_EN
  task automatic test_glitch();
    logic a;
    scl_m = 1'b1; sda_m = 1'b1; wait_clk(2*Q);
    sda_m = 1'b0; wait_clk(1);
    sda_m = 1'b1; wait_clk(2*Q);
    scl_m = 1'b0; wait_clk(Q);
    bus_write(8'h60, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL glitch_no_start: got ack %b want 1", a); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b want 0", busy); end
    bus_stop();
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_mismatch();
    test_repeated_start();
    test_back_to_back();
    test_reset_mid_read();
`ifdef I2C_GLITCH_FILTER_EN
    test_glitch();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
